hub75_bcm_sched: RTL

Scheduler that sequences the HUB75 column shifter and the panel row/latch/blank controls to produce binary-code-modulated (BCM) brightness. For each row and each bit plane it starts a shift of that plane, waits for the previous plane's on-time to expire, then blanks, latches and re-addresses the panel. Shifting of plane N+1 overlaps display of plane N. It sits between the frame-buffer read side (row select) and the PHY, and drives the shifter's `ctrl_go` / `ctrl_plane` inputs.

---
 rtl/hub75_bcm_sched.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/hub75_bcm_sched.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_bcm_sched
//  Description : Binary-code-modulation scheduler for a HUB75 panel. For each
//                row and bit plane it starts a column shift of that plane,
//                waits for the previous plane's on-time to run out and for the
//                shifter to go idle, then blanks, latches and re-addresses the
//                panel. Shifting of plane N+1 overlaps display of plane N.
//
//  Parameters  : N_ROWS       row addresses per bank (power of two)
//                N_PLANES     bit planes per colour
//                BCM_LSB_LEN  on-time of plane 0 in clk cycles; plane p gets
//                             BCM_LSB_LEN << p
//                SHIFT_LAT    cycles from shift_rdy rising until the last
//                             column clock has left the shifter
//                LOG_N_ROWS   row address width
//
//  Ports       : clk          sole clock
//                rst          synchronous active-high reset
//                ctrl_run     enable scanning (sampled in IDLE and LATCH)
//                shift_plane  one-hot plane select to the shifter
//                shift_go     one-cycle shift start pulse
//                shift_rdy    shifter idle
//                shift_row    row being shifted (frame-buffer row address)
//                phy_addr     panel row address
//                phy_le       panel latch enable
//                phy_blank    panel output disable, active high
//                frame_swap   one-cycle end-of-frame pulse
//
//  Options     : HUB75_BCM_SCHED_FRAME_SWAP_EN - when defined, frame_swap
//                pulses with the latch of the last row / last plane. When not
//                defined, frame_swap is tied low.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module hub75_bcm_sched #(
  parameter int N_ROWS      = 32,
  parameter int N_PLANES    = 8,
  parameter int BCM_LSB_LEN = 16,
  parameter int SHIFT_LAT   = 2,
  parameter int LOG_N_ROWS  = $clog2(N_ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_run,
  output logic [N_PLANES-1:0]   shift_plane,
  output logic                  shift_go,
  input  logic                  shift_rdy,
  output logic [LOG_N_ROWS-1:0] shift_row,
  output logic [LOG_N_ROWS-1:0] phy_addr,
  output logic                  phy_le,
  output logic                  phy_blank,
  output logic                  frame_swap
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int PLANE_W = (N_PLANES > 1) ? $clog2(N_PLANES) : 1;
  // Wide enough to hold the longest on-time without truncation.
  localparam int TIMER_W = $clog2(BCM_LSB_LEN << (N_PLANES - 1)) + 1;
  localparam int RDY_W   = $clog2(SHIFT_LAT + 1) + 1;

  localparam logic [RDY_W-1:0]      c_RDY_NEED   = RDY_W'(SHIFT_LAT - 1);
  localparam logic [PLANE_W-1:0]    c_LAST_PLANE = PLANE_W'(N_PLANES - 1);
  localparam logic [LOG_N_ROWS-1:0] c_LAST_ROW   = LOG_N_ROWS'(N_ROWS - 1);
  localparam logic [TIMER_W-1:0]    c_LSB_LEN    = TIMER_W'(BCM_LSB_LEN);
  localparam logic [N_PLANES-1:0]   c_PLANE0_OH  = N_PLANES'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_SWAIT = 3'd2,
    S_BLANK = 3'd3,
    S_LATCH = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic [LOG_N_ROWS-1:0] r_row;           // cursor row
  logic [PLANE_W-1:0]    r_plane;         // cursor plane
  logic [TIMER_W-1:0]    r_timer;         // remaining on-time of displayed plane
  logic [RDY_W-1:0]      r_rdy_cnt;       // earlier consecutive shift_rdy-high cycles (saturating)
  logic                  r_swait_first;   // first SWAIT cycle after SHIFT

  logic [N_PLANES-1:0]   r_shift_plane;
  logic                  r_shift_go;
  logic [LOG_N_ROWS-1:0] r_shift_row;
  logic [LOG_N_ROWS-1:0] r_phy_addr;
  logic                  r_phy_le;
  logic                  r_phy_blank;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                  w_timer_zero;
  logic                  w_last_plane;
  logic                  w_last_row;
  logic                  w_rdy_ok;
  logic                  w_swait_exit;
  logic [TIMER_W-1:0]    w_load;
  logic [N_PLANES-1:0]   w_plane_oh;

  assign w_timer_zero = (r_timer == '0);
  assign w_last_plane = (r_plane == c_LAST_PLANE);
  assign w_last_row   = (r_row == c_LAST_ROW);
  assign w_load       = c_LSB_LEN << r_plane;
  assign w_plane_oh   = c_PLANE0_OH << r_plane;

  // The shifter has been idle for SHIFT_LAT consecutive cycles: the current
  // cycle plus SHIFT_LAT-1 earlier ones. The first SWAIT cycle never
  // qualifies, so a shifter that has not yet reacted to shift_go cannot be
  // mistaken for a finished one.
  assign w_rdy_ok     = !r_swait_first && shift_rdy && (r_rdy_cnt >= c_RDY_NEED);
  assign w_swait_exit = w_rdy_ok && w_timer_zero;

  // --------------------------------------------------------------------------
  // Scheduler FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_row         <= '0;
      r_plane       <= '0;
      r_timer       <= '0;
      r_rdy_cnt     <= '0;
      r_swait_first <= 1'b0;
      r_shift_plane <= c_PLANE0_OH;
      r_shift_go    <= 1'b0;
      r_shift_row   <= '0;
      r_phy_addr    <= '0;
      r_phy_le      <= 1'b0;
      r_phy_blank   <= 1'b1;
    end else begin
      // Pulses default low.
      r_shift_go <= 1'b0;
      r_phy_le   <= 1'b0;

      // On-time countdown; a load in BLANK below takes priority.
      if (!w_timer_zero) begin
        r_timer <= r_timer - TIMER_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          r_phy_blank <= 1'b1;
          if (ctrl_run) begin
            r_state       <= S_SHIFT;
            r_shift_go    <= 1'b1;
            r_shift_plane <= w_plane_oh;
            r_shift_row   <= r_row;
          end
        end

        S_SHIFT: begin
          r_state       <= S_SWAIT;
          r_swait_first <= 1'b1;
          r_rdy_cnt     <= '0;
        end

        S_SWAIT: begin
          r_swait_first <= 1'b0;
          if (!shift_rdy || r_swait_first) begin
            r_rdy_cnt <= '0;
          end else if (r_rdy_cnt != c_RDY_NEED) begin
            r_rdy_cnt <= r_rdy_cnt + RDY_W'(1);
          end
          // If the shift outlasts the on-time, the display window simply
          // stretches until the shift is complete.
          if (w_swait_exit) begin
            r_state     <= S_BLANK;
            r_phy_blank <= 1'b1;
          end
        end

        S_BLANK: begin
          // Entering LATCH: present the shifted row and start its on-time.
          // The cursor equals the just-shifted row/plane until this point.
          r_state     <= S_LATCH;
          r_phy_le    <= 1'b1;
          r_phy_blank <= 1'b1;
          r_phy_addr  <= r_row;
          r_timer     <= w_load;
          if (w_last_plane) begin
            r_plane <= '0;
            r_row   <= w_last_row ? '0 : (r_row + LOG_N_ROWS'(1));
          end else begin
            r_plane <= r_plane + PLANE_W'(1);
          end
        end

        S_LATCH: begin
          r_phy_blank <= 1'b0;
          if (ctrl_run) begin
            // Start shifting the next plane while this one is on display.
            r_state       <= S_SHIFT;
            r_shift_go    <= 1'b1;
            r_shift_plane <= w_plane_oh;
            r_shift_row   <= r_row;
          end else begin
            // A later restart always begins a fresh frame.
            r_state <= S_DRAIN;
            r_row   <= '0;
            r_plane <= '0;
          end
        end

        S_DRAIN: begin
          if (w_timer_zero) begin
            r_state     <= S_IDLE;
            r_phy_blank <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_phy_blank <= 1'b1;
        end
      endcase
    end
  end

  assign shift_plane = r_shift_plane;
  assign shift_go    = r_shift_go;
  assign shift_row   = r_shift_row;
  assign phy_addr    = r_phy_addr;
  assign phy_le      = r_phy_le;
  assign phy_blank   = r_phy_blank;

  // --------------------------------------------------------------------------
  // End-of-frame pulse, aligned with the LATCH of the last row / last plane
  // --------------------------------------------------------------------------
`ifdef HUB75_BCM_SCHED_FRAME_SWAP_EN
  logic r_frame_swap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_swap <= 1'b0;
    end else begin
      r_frame_swap <= (r_state == S_BLANK) && w_last_plane && w_last_row;
    end
  end

  assign frame_swap = r_frame_swap;
`else
  assign frame_swap = 1'b0;
`endif

endmodule
`default_nettype wire
